// File: rtl/nn_stage_pkg.sv
// Shared definitions for the neural-net stage address logic: width helpers
// and the job FSM state encoding.
package nn_stage_pkg;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    // Bit width needed to index n items, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/nn_wrap_counter.sv
// Up-counter 0..MAX that wraps to zero and flags the wrapping increment,
// used as one digit of a mixed-radix sweep.
module nn_wrap_counter
    import nn_stage_pkg::*;
#(
    parameter int MAX = 1,
    localparam int W = clog2_min1(MAX + 1)
) (
    input  logic         clock,
    input  logic         clear_n,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         wrap
);

    logic atMax;

    assign atMax = (count == W'(MAX));
    assign wrap  = inc & atMax;

    always_ff @(posedge clock) begin
        if (!clear_n) begin
            count <= '0;
        end else if (inc) begin
            count <= atMax ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/quadrant_address_sequencer.sv
// Sweeps one image tile (or every tile in turn) and emits paired weight and
// input memory addresses under a start/done job handshake with backpressure.
module quadrant_address_sequencer
    import nn_stage_pkg::*;
#(
    parameter int TILE           = 16,
    parameter int TILES_PER_SIDE = 2,
    parameter int ELEMS          = 4,
    parameter int VECTORS        = 4,
    localparam int NT    = TILES_PER_SIDE * TILES_PER_SIDE,
    localparam int IMG_W = TILE * TILES_PER_SIDE,
    localparam int TW    = clog2_min1(NT),
    localparam int WAW   = clog2_min1(VECTORS * ELEMS),
    localparam int IAW   = clog2_min1(IMG_W * IMG_W * ELEMS)
) (
    input  logic           clock,
    input  logic           clear_n,
    input  logic           start,
    input  logic [TW-1:0]  tile_sel,
    input  logic           all_tiles,
    output logic           busy,
    output logic           done,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [WAW-1:0] weight_address,
    output logic [IAW-1:0] input_address,
    output logic [TW-1:0]  out_tile,
    output logic           out_vector_last,
    output logic           out_last
);

    localparam int EW = clog2_min1(ELEMS);
    localparam int PW = clog2_min1(TILE);
    localparam int VW = clog2_min1(VECTORS);

    state_t        state_q;
    logic          busy_q;
    logic          done_q;
    logic          valid_q;
    logic          allTiles_q;
    logic [TW-1:0] tileSel_q;

    logic [EW-1:0] eCnt;
    logic [PW-1:0] cCnt;
    logic [PW-1:0] rCnt;
    logic [VW-1:0] vCnt;
    logic [TW-1:0] tCnt;
    logic          eWrap, cWrap, rWrap, vWrap, tWrap;

    logic          transfer;
    logic          jobEnd;
    logic [TW-1:0] tileIdx;
    logic [31:0]   pixY;
    logic [31:0]   pixX;

    assign transfer = valid_q & out_ready;

    // Digits of the sweep, innermost first; each carries into the next.
    nn_wrap_counter #(.MAX(ELEMS - 1)) uElem (
        .clock(clock), .clear_n(clear_n), .inc(transfer), .count(eCnt), .wrap(eWrap)
    );
    nn_wrap_counter #(.MAX(TILE - 1)) uCol (
        .clock(clock), .clear_n(clear_n), .inc(eWrap), .count(cCnt), .wrap(cWrap)
    );
    nn_wrap_counter #(.MAX(TILE - 1)) uRow (
        .clock(clock), .clear_n(clear_n), .inc(cWrap), .count(rCnt), .wrap(rWrap)
    );
    nn_wrap_counter #(.MAX(VECTORS - 1)) uVec (
        .clock(clock), .clear_n(clear_n), .inc(rWrap), .count(vCnt), .wrap(vWrap)
    );
    // The tile digit only moves in all-tiles mode and wraps back to zero on
    // the final beat, so every counter is already zero when a job starts.
    nn_wrap_counter #(.MAX(NT - 1)) uTile (
        .clock(clock), .clear_n(clear_n), .inc(vWrap & allTiles_q), .count(tCnt), .wrap(tWrap)
    );

    assign jobEnd  = allTiles_q ? tWrap : vWrap;
    assign tileIdx = allTiles_q ? tCnt : tileSel_q;

    assign pixY = (32'(tileIdx) / 32'(TILES_PER_SIDE)) * 32'(TILE) + 32'(rCnt);
    assign pixX = (32'(tileIdx) % 32'(TILES_PER_SIDE)) * 32'(TILE) + 32'(cCnt);

    assign weight_address  = WAW'(32'(vCnt) * 32'(ELEMS) + 32'(eCnt));
    assign input_address   = IAW'((pixY * 32'(IMG_W) + pixX) * 32'(ELEMS) + 32'(eCnt));
    assign out_tile        = tileIdx;
    assign out_vector_last = (eCnt == EW'(ELEMS - 1)) & (cCnt == PW'(TILE - 1))
                           & (rCnt == PW'(TILE - 1));
    assign out_last        = out_vector_last & (vCnt == VW'(VECTORS - 1))
                           & (!allTiles_q | (tCnt == TW'(NT - 1)));

    assign busy      = busy_q;
    assign done      = done_q;
    assign out_valid = valid_q;

    always_ff @(posedge clock) begin
        if (!clear_n) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            valid_q    <= 1'b0;
            allTiles_q <= 1'b0;
            tileSel_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q    <= RUN;
                        busy_q     <= 1'b1;
                        valid_q    <= 1'b1;
                        allTiles_q <= all_tiles;
                        tileSel_q  <= (NT > 1) ? tile_sel : '0;
                    end
                end
                RUN: begin
                    if (jobEnd) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        valid_q <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_quadrant_address_sequencer.sv
// Directed bench for quadrant_address_sequencer: a beat-index model checks
// every cycle, directed jobs pin literal addresses and handshake timing.
module tb_quadrant_address_sequencer;

    localparam int TILE    = 16;
    localparam int TPS     = 2;
    localparam int ELEMS   = 4;
    localparam int VECTORS = 4;
    localparam int NT      = TPS * TPS;
    localparam int IMG_W   = TILE * TPS;
    localparam int PASS    = TILE * TILE * ELEMS;
    localparam int BPT     = VECTORS * PASS;

    logic        clock;
    logic        clear_n;
    logic        start;
    logic [1:0]  tile_sel;
    logic        all_tiles;
    logic        busy;
    logic        done;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  weight_address;
    logic [11:0] input_address;
    logic [1:0]  out_tile;
    logic        out_vector_last;
    logic        out_last;

    quadrant_address_sequencer dut (
        .clock(clock), .clear_n(clear_n), .start(start), .tile_sel(tile_sel),
        .all_tiles(all_tiles), .busy(busy), .done(done), .out_valid(out_valid),
        .out_ready(out_ready), .weight_address(weight_address),
        .input_address(input_address), .out_tile(out_tile),
        .out_vector_last(out_vector_last), .out_last(out_last)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, expected);
        end
    endtask

    // Expected beat fields derived directly from the beat's position in the job.
    function automatic int expWeight(input int idx);
        return ((idx / PASS) % VECTORS) * ELEMS + idx % ELEMS;
    endfunction

    function automatic int expTile(input int idx, input bit all, input int sel);
        return all ? idx / BPT : sel;
    endfunction

    function automatic int expInput(input int idx, input int tile);
        int e = idx % ELEMS;
        int c = (idx / ELEMS) % TILE;
        int r = (idx / (ELEMS * TILE)) % TILE;
        int y = (tile / TPS) * TILE + r;
        int x = (tile % TPS) * TILE + c;
        return (y * IMG_W + x) * ELEMS + e;
    endfunction

    function automatic bit expVLast(input int idx);
        return (idx % PASS) == PASS - 1;
    endfunction

    function automatic bit expLast(input int idx, input bit all);
        return idx == (all ? NT * BPT : BPT) - 1;
    endfunction

    bit mArmed = 0;
    bit mBusy  = 0;
    bit mDone  = 0;
    bit mAll   = 0;
    int mSel   = 0;
    int mIdx   = 0;
    int dutXfers = 0;
    int dutDones = 0;

    // Per-cycle comparison against the model, then advance the model from
    // the inputs that the next rising edge will sample.
    always @(negedge clock) begin
        if (mArmed) begin
            checkOutput("busy", busy, mBusy);
            checkOutput("out_valid", out_valid, mBusy);
            checkOutput("done", done, mDone);
            if (mBusy) begin
                checkOutput("weight_address", weight_address, expWeight(mIdx));
                checkOutput("out_tile", out_tile, expTile(mIdx, mAll, mSel));
                checkOutput("input_address", input_address,
                            expInput(mIdx, expTile(mIdx, mAll, mSel)));
                checkOutput("out_vector_last", out_vector_last, expVLast(mIdx));
                checkOutput("out_last", out_last, expLast(mIdx, mAll));
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) dutXfers++;
            if (done === 1'b1) dutDones++;
        end
        if (!clear_n) begin
            mBusy  = 0;
            mDone  = 0;
            mArmed = 1;
        end else if (mBusy) begin
            mDone = 0;
            if (out_ready) begin
                if (mIdx == (mAll ? NT * BPT : BPT) - 1) begin
                    mBusy = 0;
                    mDone = 1;
                end else begin
                    mIdx++;
                end
            end
        end else begin
            mDone = 0;
            if (start) begin
                mBusy = 1;
                mIdx  = 0;
                mAll  = all_tiles;
                mSel  = int'(tile_sel);
            end
        end
    end

    task automatic applyStimulus(input bit st, input int sel, input bit all, input bit rdy);
        start     = st;
        tile_sel  = 2'(sel);
        all_tiles = all;
        out_ready = rdy;
    endtask

    task automatic stepCycles(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic waitDone(input string name, input int budget, input bit randomReady);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            if (randomReady) out_ready = 1'($urandom_range(0, 1));
            stepCycles(1);
            n++;
        end
        out_ready = 1'b1;
        checkOutput({name, " done seen"}, done === 1'b1, 1);
    endtask

    task automatic checkJobCounts(input string name, input int x0, input int d0, input int beats);
        stepCycles(2);
        checkOutput({name, " transfers"}, dutXfers - x0, beats);
        checkOutput({name, " done pulses"}, dutDones - d0, 1);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int x0;
        int d0;

        clear_n = 1'b0;
        applyStimulus(1, 0, 0, 1);

        checkOutput("model beat5 input", expInput(5, 0), 5);
        checkOutput("model beat64 input", expInput(64, 0), 128);
        checkOutput("model beat4095 input", expInput(4095, 0), 1983);
        checkOutput("model beat4095 weight", expWeight(4095), 15);
        checkOutput("model tile3 first input", expInput(0, 3), 2112);
        checkOutput("model all-tiles beat4096 tile", expTile(4096, 1, 2), 1);

        repeat (3) begin
            stepCycles(1);
            checkOutput("reset busy", busy, 0);
            checkOutput("reset done", done, 0);
            checkOutput("reset out_valid", out_valid, 0);
        end

        // Start held through reset is accepted on the first edge after release.
        clear_n = 1'b1;
        x0 = dutXfers;
        d0 = dutDones;
        stepCycles(1);
        start = 1'b0;
        checkOutput("tile0 first beat valid", out_valid, 1);
        checkOutput("tile0 beat0 weight", weight_address, 0);
        checkOutput("tile0 beat0 input", input_address, 0);
        stepCycles(5);
        checkOutput("tile0 beat5 input", input_address, 5);
        stepCycles(59);
        checkOutput("tile0 beat64 input", input_address, 128);
        stepCycles(1023 - 64);
        checkOutput("tile0 beat1023 vector_last", out_vector_last, 1);
        stepCycles(4095 - 1023);
        checkOutput("tile0 beat4095 weight", weight_address, 15);
        checkOutput("tile0 beat4095 input", input_address, 1983);
        checkOutput("tile0 beat4095 last", out_last, 1);
        stepCycles(1);
        checkOutput("tile0 done pulse", done, 1);
        checkOutput("tile0 busy after", busy, 0);
        checkJobCounts("tile0", x0, d0, BPT);

        x0 = dutXfers;
        d0 = dutDones;
        applyStimulus(1, 3, 0, 1);
        stepCycles(1);
        start = 1'b0;
        checkOutput("tile3 first input", input_address, 2112);
        checkOutput("tile3 first tile", out_tile, 3);
        stepCycles(4095);
        checkOutput("tile3 last input", input_address, 4095);
        checkOutput("tile3 last tile", out_tile, 3);
        checkOutput("tile3 last flag", out_last, 1);
        waitDone("tile3", 10, 0);
        checkJobCounts("tile3", x0, d0, BPT);

        x0 = dutXfers;
        d0 = dutDones;
        applyStimulus(1, 1, 0, 0);
        stepCycles(1);
        start = 1'b0;
        waitDone("tile1 random ready", 40000, 1);
        checkJobCounts("tile1 random ready", x0, d0, BPT);

        x0 = dutXfers;
        d0 = dutDones;
        applyStimulus(1, 2, 1, 1);
        stepCycles(1);
        start = 1'b0;
        checkOutput("all beat0 tile", out_tile, 0);
        stepCycles(4095);
        checkOutput("all beat4095 tile", out_tile, 0);
        checkOutput("all beat4095 not last", out_last, 0);
        stepCycles(1);
        checkOutput("all beat4096 tile", out_tile, 1);
        checkOutput("all beat4096 input", input_address, 64);
        stepCycles(5000 - 4096);
        applyStimulus(1, 1, 0, 1);
        stepCycles(1);
        start = 1'b0;
        stepCycles(16383 - 5001);
        checkOutput("all beat16383 tile", out_tile, 3);
        checkOutput("all beat16383 input", input_address, 4095);
        checkOutput("all beat16383 last", out_last, 1);
        waitDone("all tiles", 10, 0);
        checkJobCounts("all tiles", x0, d0, NT * BPT);

        d0 = dutDones;
        applyStimulus(1, 0, 0, 1);
        stepCycles(1);
        start = 1'b0;
        stepCycles(1000);
        clear_n = 1'b0;
        stepCycles(1);
        checkOutput("abort busy", busy, 0);
        checkOutput("abort out_valid", out_valid, 0);
        checkOutput("abort done", done, 0);
        clear_n = 1'b1;
        stepCycles(5);
        checkOutput("abort no done pulse", dutDones - d0, 0);
        x0 = dutXfers;
        d0 = dutDones;
        applyStimulus(1, 0, 0, 1);
        stepCycles(1);
        start = 1'b0;
        checkOutput("replay beat0 valid", out_valid, 1);
        checkOutput("replay beat0 input", input_address, 0);
        waitDone("replay", 5000, 0);
        checkJobCounts("replay", x0, d0, BPT);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
